// File: rtl/receiver_pkg.sv
// Types shared by the ADC front end and the downstream DSP chain.
package receiver_pkg;

   localparam int unsigned SampleBits = 12;

   typedef logic [SampleBits-1:0] sample_t;

   typedef enum logic [2:0] {
      StIdle,
      StSetup,
      StShiftLo,
      StShiftHi,
      StDone,
      StQuiet
   } adc_state_t;

   // Counter width able to hold max_count without wrapping.
   function automatic int unsigned cnt_width(int unsigned max_count);
      return $clog2(max_count) + 1;
   endfunction

endpackage

// File: rtl/sclk_phase_timer.sv
// Counts CLK_DIV clocks per SCLK half-period; phase_done_o marks the last one.
module sclk_phase_timer
   import receiver_pkg::*;
#(
   parameter int unsigned CLK_DIV = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic start_i,
   output logic phase_done_o
);

   localparam int unsigned CntW = cnt_width(CLK_DIV);

   logic [CntW-1:0] cnt_q, cnt_d;

   assign phase_done_o = (cnt_q == CntW'(CLK_DIV - 1));

   // Hold at zero while start_i is high, otherwise wrap after each phase.
   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (start_i || phase_done_o) begin
         cnt_d = '0;
      end
   end

   // Phase counter register.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/adc_spi_sampler.sv
// One SPI read (CPOL=1) of a serial ADC per enable pulse; presents the sample
// with a one-cycle valid strobe and flags enables dropped while busy.
module adc_spi_sampler
   import receiver_pkg::*;
#(
   parameter int unsigned CLK_DIV      = 2,
   parameter int unsigned FRAME_BITS   = 16,
   parameter int unsigned LEAD_BITS    = 4,
   parameter int unsigned SAMPLE_BITS  = 12,
   parameter int unsigned QUIET_CYCLES = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en_i,
   input  logic                   miso_i,
   output logic                   sclk_o,
   output logic                   cs_n_o,
   output logic [SAMPLE_BITS-1:0] sample_o,
   output logic                   valid_o,
   output logic                   busy_o,
   output logic                   overrun_o
);

   if (LEAD_BITS + SAMPLE_BITS > FRAME_BITS) begin : g_bad_frame
      $error("adc_spi_sampler: LEAD_BITS + SAMPLE_BITS exceeds FRAME_BITS");
   end
   if (CLK_DIV < 1 || QUIET_CYCLES < 1) begin : g_bad_timing
      $error("adc_spi_sampler: CLK_DIV and QUIET_CYCLES must be at least 1");
   end

   // Leading bits are never needed, so they simply fall off the top.
   localparam int unsigned ShiftW = FRAME_BITS - LEAD_BITS;
   localparam int unsigned BitW   = cnt_width(FRAME_BITS);
   localparam int unsigned QuietW = cnt_width(QUIET_CYCLES);

   adc_state_t               state_q, state_d;
   logic                     sclk_q, sclk_d;
   logic                     cs_n_q, cs_n_d;
   logic [SAMPLE_BITS-1:0]   sample_q, sample_d;
   logic                     valid_q, valid_d;
   logic                     busy_q, busy_d;
   logic                     overrun_q, overrun_d;
   logic [ShiftW-1:0]        shift_q, shift_d;
   logic [BitW-1:0]          bit_cnt_q, bit_cnt_d;
   logic [QuietW-1:0]        quiet_cnt_q, quiet_cnt_d;
   logic                     timer_start;
   logic                     phase_done;

   // Timer runs only in the SCLK-timed states and restarts from zero on entry.
   assign timer_start = !(state_q inside {StSetup, StShiftLo, StShiftHi});

   sclk_phase_timer #(
      .CLK_DIV(CLK_DIV)
   ) u_phase_timer (
      .clk_i       (clk),
      .rst_ni      (rst),
      .start_i     (timer_start),
      .phase_done_o(phase_done)
   );

   // Next-state and registered-output logic.
   always_comb begin
      state_d     = state_q;
      sclk_d      = sclk_q;
      cs_n_d      = cs_n_q;
      sample_d    = sample_q;
      valid_d     = 1'b0;
      busy_d      = busy_q;
      overrun_d   = en_i && (state_q != StIdle);
      shift_d     = shift_q;
      bit_cnt_d   = bit_cnt_q;
      quiet_cnt_d = quiet_cnt_q;

      unique case (state_q)
         StIdle: begin
            if (en_i) begin
               state_d   = StSetup;
               cs_n_d    = 1'b0;
               busy_d    = 1'b1;
               bit_cnt_d = '0;
               shift_d   = '0;
            end
         end
         StSetup: begin
            if (phase_done) begin
               state_d = StShiftLo;
               sclk_d  = 1'b0;
            end
         end
         StShiftLo: begin
            // ADC data is stable here; capture on the rising SCLK edge.
            if (phase_done) begin
               state_d   = StShiftHi;
               sclk_d    = 1'b1;
               shift_d   = ShiftW'({shift_q, miso_i});
               bit_cnt_d = bit_cnt_q + 1'b1;
            end
         end
         StShiftHi: begin
            if (phase_done) begin
               if (bit_cnt_q == BitW'(FRAME_BITS)) begin
                  state_d  = StDone;
                  cs_n_d   = 1'b1;
                  sample_d = shift_q[ShiftW-1 -: SAMPLE_BITS];
                  valid_d  = 1'b1;
               end else begin
                  state_d = StShiftLo;
                  sclk_d  = 1'b0;
               end
            end
         end
         StDone: begin
            state_d     = StQuiet;
            quiet_cnt_d = '0;
         end
         StQuiet: begin
            if (quiet_cnt_q == QuietW'(QUIET_CYCLES - 1)) begin
               state_d = StIdle;
               busy_d  = 1'b0;
            end else begin
               quiet_cnt_d = quiet_cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and output registers; reset wins over every input.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= StIdle;
         sclk_q      <= 1'b1;
         cs_n_q      <= 1'b1;
         sample_q    <= '0;
         valid_q     <= 1'b0;
         busy_q      <= 1'b0;
         overrun_q   <= 1'b0;
         shift_q     <= '0;
         bit_cnt_q   <= '0;
         quiet_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         sclk_q      <= sclk_d;
         cs_n_q      <= cs_n_d;
         sample_q    <= sample_d;
         valid_q     <= valid_d;
         busy_q      <= busy_d;
         overrun_q   <= overrun_d;
         shift_q     <= shift_d;
         bit_cnt_q   <= bit_cnt_d;
         quiet_cnt_q <= quiet_cnt_d;
      end
   end

   assign sclk_o    = sclk_q;
   assign cs_n_o    = cs_n_q;
   assign sample_o  = sample_q;
   assign valid_o   = valid_q;
   assign busy_o    = busy_q;
   assign overrun_o = overrun_q;

endmodule

// File: tb/tb_adc_spi_sampler.sv
// Scoreboard bench: three sampler instances (CLK_DIV 2, 1, 5) share clock and
// reset; a timing model predicts valid/overrun strobes and cs_n/busy windows.
module tb_adc_spi_sampler;
   import receiver_pkg::*;

   localparam int NI = 3;

   typedef struct {
      int          inst;
      bit          ovr;
      int unsigned t;
      sample_t     s;
   } exp_t;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic           rst_prev = 1'b1;
   logic [NI-1:0]  en_v = '0;
   logic [15:0]    adc_frame [NI];
   logic [NI-1:0]  sclk_v, cs_n_v, valid_v, busy_v, ovr_v;
   sample_t        sample_a [NI];
   int unsigned    cyc = 0;

   int unsigned    free_at [NI];
   int unsigned    cs_lo [NI];
   int unsigned    cs_hi [NI];
   int unsigned    bz_hi [NI];
   exp_t           exp_q [$];

   sample_t        exp_last [NI];
   logic           prev_sclk [NI];
   logic           prev_cs [NI];
   int             rises [NI];

   int             n_checks = 0;
   int             n_fail = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc      <= cyc + 1;
      rst_prev <= rst;
   end

   function automatic int unsigned cd_of(int i);
      case (i)
         0:       return 2;
         1:       return 1;
         default: return 5;
      endcase
   endfunction

   function automatic int unsigned qc_of(int i);
      return (i == 2) ? 2 : 4;
   endfunction

   for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int unsigned CD = (g == 0) ? 2 : (g == 1) ? 1 : 5;
      localparam int unsigned QC = (g == 2) ? 2 : 4;
      logic    miso = 1'b0;
      logic    sclk_w, cs_n_w, valid_w, busy_w, ovr_w;
      sample_t sample_w;
      int      idx = 0;

      adc_spi_sampler #(
         .CLK_DIV     (CD),
         .FRAME_BITS  (16),
         .LEAD_BITS   (4),
         .SAMPLE_BITS (12),
         .QUIET_CYCLES(QC)
      ) u_dut (
         .clk      (clk),
         .rst      (rst),
         .en_i     (en_v[g]),
         .miso_i   (miso),
         .sclk_o   (sclk_w),
         .cs_n_o   (cs_n_w),
         .sample_o (sample_w),
         .valid_o  (valid_w),
         .busy_o   (busy_w),
         .overrun_o(ovr_w)
      );

      assign sclk_v[g]   = sclk_w;
      assign cs_n_v[g]   = cs_n_w;
      assign valid_v[g]  = valid_w;
      assign busy_v[g]   = busy_w;
      assign ovr_v[g]    = ovr_w;
      assign sample_a[g] = sample_w;

      // ADC: presents the next frame bit (MSB first) after each SCLK fall.
      always @(negedge sclk_w or posedge cs_n_w) begin
         if (cs_n_w) begin
            idx = 0;
         end else if (idx < 16) begin
            miso = adc_frame[g][15 - idx];
            idx++;
         end
      end
   end

   function automatic void chk(string name, int i, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s inst%0d cycle %0d: got 0x%0h expected 0x%0h", name, i, cyc, act, exp);
      end
   endfunction

   function automatic int find_exp(int i, bit ovr);
      for (int j = 0; j < exp_q.size(); j++) begin
         if (exp_q[j].inst == i && exp_q[j].ovr == ovr) return j;
      end
      return -1;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference model: a frame takes 2*16+1 SCLK half-periods from acceptance
   // to valid, then QUIET cycles before the next enable can be taken.
   task automatic model_en(int i, sample_t s);
      int unsigned t = cyc;
      int unsigned cd = cd_of(i);
      if (t >= free_at[i]) begin
         adc_frame[i] = {4'($urandom), s};
         exp_q.push_back('{inst: i, ovr: 1'b0, t: t + 1 + 33 * cd, s: s});
         cs_lo[i]   = t + 1;
         cs_hi[i]   = t + 33 * cd;
         bz_hi[i]   = t + 1 + 33 * cd + qc_of(i);
         free_at[i] = bz_hi[i] + 1;
      end else begin
         exp_q.push_back('{inst: i, ovr: 1'b1, t: t + 1, s: '0});
      end
   endtask

   task automatic fire(int i, sample_t s);
      en_v[i] = 1'b1;
      model_en(i, s);
      step();
      en_v[i] = 1'b0;
   endtask

   task automatic wait_free(int i);
      while (cyc < free_at[i]) step();
   endtask

   task automatic do_reset(int k);
      int unsigned tr = cyc;
      rst = 1'b0;
      for (int i = 0; i < NI; i++) begin
         if (cs_hi[i] > tr) cs_hi[i] = tr;
         if (bz_hi[i] > tr) bz_hi[i] = tr;
         free_at[i] = tr + k;
      end
      for (int j = exp_q.size() - 1; j >= 0; j--) begin
         if (exp_q[j].t >= tr + 1) exp_q.delete(j);
      end
      repeat (k) step();
      rst = 1'b1;
   endtask

   // Monitor: compares every instance each cycle against the model.
   always @(negedge clk) begin
      for (int i = 0; i < NI; i++) begin
         int j;
         if (!rst_prev) begin
            chk("reset_state", i,
                {cs_n_v[i], sclk_v[i], valid_v[i], busy_v[i], ovr_v[i], sample_a[i]},
                32'h18000);
            exp_last[i] = '0;
         end else begin
            chk("cs_n", i, cs_n_v[i], !(cyc >= cs_lo[i] && cyc <= cs_hi[i]));
            chk("busy", i, busy_v[i], (cyc >= cs_lo[i] && cyc <= bz_hi[i]));
            if (cs_n_v[i]) chk("sclk_idle", i, sclk_v[i], 1);
            if (valid_v[i]) begin
               j = find_exp(i, 1'b0);
               chk("valid_expected", i, (j >= 0), 1);
               if (j >= 0) begin
                  chk("valid_time", i, cyc, exp_q[j].t);
                  chk("sample", i, sample_a[i], exp_q[j].s);
                  chk("sclk_rises", i, rises[i], 16);
                  exp_last[i] = exp_q[j].s;
                  exp_q.delete(j);
               end
            end else begin
               chk("sample_hold", i, sample_a[i], exp_last[i]);
            end
            if (ovr_v[i]) begin
               j = find_exp(i, 1'b1);
               chk("overrun_expected", i, (j >= 0), 1);
               if (j >= 0) begin
                  chk("overrun_time", i, cyc, exp_q[j].t);
                  exp_q.delete(j);
               end
            end
         end
         if (prev_cs[i] && !cs_n_v[i]) begin
            rises[i] = 0;
         end else if (!prev_sclk[i] && sclk_v[i] && !cs_n_v[i]) begin
            rises[i]++;
         end
         prev_cs[i]   = cs_n_v[i];
         prev_sclk[i] = sclk_v[i];
      end
   end

   initial begin
      int unsigned last;
      for (int i = 0; i < NI; i++) begin
         free_at[i]   = 0;
         cs_lo[i]     = 1;
         cs_hi[i]     = 0;
         bz_hi[i]     = 0;
         exp_last[i]  = '0;
         prev_sclk[i] = 1'b1;
         prev_cs[i]   = 1'b1;
         rises[i]     = 0;
         adc_frame[i] = '0;
      end
      rst = 1'b0;
      #1;
      repeat (3) step();
      rst = 1'b1;
      for (int i = 0; i < NI; i++) free_at[i] = cyc;

      // Directed sequences, one instance at a time.
      for (int i = 0; i < NI; i++) begin
         fire(i, 12'hABC);
         wait_free(i);
         fire(i, 12'hFFF);
         wait_free(i);
         fire(i, 12'h001);
         wait_free(i);
         fire(i, sample_t'($urandom));
         repeat (19) step();
         fire(i, sample_t'($urandom));
         wait_free(i);
         fire(i, sample_t'($urandom));
         repeat (29) step();
         do_reset(1);
         fire(i, sample_t'($urandom));
         wait_free(i);
         fire(i, 12'h000);
         wait_free(i);
         fire(i, 12'h800);
         wait_free(i);
         fire(i, 12'hFFF);
         wait_free(i);
      end

      // Random enables (some exactly at the free boundary) and sparse resets.
      for (int n = 0; n < 4000; n++) begin
         if ($urandom_range(0, 499) == 0) begin
            do_reset(int'($urandom_range(1, 2)));
         end else begin
            for (int i = 0; i < NI; i++) begin
               if ($urandom_range(0, 59) == 0 ||
                   (cyc == free_at[i] && $urandom_range(0, 1) == 0)) begin
                  en_v[i] = 1'b1;
                  model_en(i, sample_t'($urandom));
               end
            end
            step();
            en_v = '0;
         end
      end

      last = 0;
      for (int i = 0; i < NI; i++) if (free_at[i] > last) last = free_at[i];
      while (cyc < last + 3) step();
      chk("pending_expectations", -1, exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/adc_spi_sampler.md
Name: adc_spi_sampler

Overview:
Consumes the periodic one-cycle sample-enable pulse and performs one SPI read of an external serial ADC per pulse (CPOL=1, 16-bit frame: 4 leading zeros then 12 data bits, MSB first). Extracts the sample word and presents it with a one-cycle valid strobe to the downstream DSP chain. Flags enables that arrive while a conversion is still in progress.

Parameters:
CLK_DIV, 2, system clocks per SCLK half-period; legal range >= 1
FRAME_BITS, 16, SCLK cycles per conversion frame
LEAD_BITS, 4, leading frame bits discarded before the sample MSB
SAMPLE_BITS, 12, sample width; elaboration error if LEAD_BITS+SAMPLE_BITS > FRAME_BITS
QUIET_CYCLES, 4, clocks with cs_n_o high after a frame before a new enable is accepted; legal range >= 1

Ports:
clk  input  1  system clock; all logic on its rising edge
rst  input  1  synchronous, active-low reset
en_i  input  1  one-cycle sample trigger from the enable generator
miso_i  input  1  ADC serial data out; changes after SCLK falling edges
sclk_o  output  1  SPI clock; registered; idles high
cs_n_o  output  1  ADC chip select, active low; registered
sample_o  output  SAMPLE_BITS  last captured sample, unsigned
valid_o  output  1  one-cycle strobe: sample_o updated this cycle
busy_o  output  1  high from frame start until the quiet period ends
overrun_o  output  1  one-cycle pulse: en_i dropped because busy

Behaviour:
- Reset (rst=0 at a clk edge): state IDLE; cs_n_o=1, sclk_o=1, sample_o=0, valid_o=0, busy_o=0, overrun_o=0; shift register and counters cleared. Reset overrides all other inputs, including en_i.
- States: IDLE, SETUP, SHIFT_LO, SHIFT_HI, DONE, QUIET.
- IDLE: en_i=1 -> SETUP. At that edge cs_n_o<=0 and busy_o<=1.
- SETUP: CLK_DIV cycles with sclk_o=1. Then -> SHIFT_LO with sclk_o<=0.
- SHIFT_LO: CLK_DIV cycles. At the last cycle edge: sclk_o<=1, shift_reg<={shift_reg,miso_i}, bit_cnt++, -> SHIFT_HI.
- SHIFT_HI: CLK_DIV cycles. Then, if bit_cnt==FRAME_BITS -> DONE; otherwise -> SHIFT_LO with sclk_o<=0.
- DONE: one cycle.
  - At entry edge: cs_n_o<=1, sample_o<=shift_reg[FRAME_BITS-1-LEAD_BITS -: SAMPLE_BITS], valid_o<=1.
  - Trailing frame bits are discarded. -> QUIET.
- QUIET: QUIET_CYCLES cycles with cs_n_o=1. Then -> IDLE with busy_o<=0.
- Latency: if en_i is high at edge t0, then:
  - cs_n_o falls at t0+1;
  - bit k is captured at t0+1+(2k+2)*CLK_DIV;
  - valid_o is high during cycle t0+1+33*CLK_DIV (t0+67 for defaults);
  - busy_o falls at t0+2+33*CLK_DIV+QUIET_CYCLES.
- Overrun: en_i=1 in any state other than IDLE -> overrun_o=1 the next cycle. The enable is dropped, not queued, and the current frame is unaffected.
- An en_i arriving in the same cycle busy_o deasserts (the IDLE cycle) is accepted.
- sample_o holds its value between valid strobes. valid_o never asserts for a frame interrupted by reset.
- Reset mid-frame: cs_n_o returns high at the next edge; the partial frame is lost.
- Counter widths: $clog2 of the maximum count plus 1. No wrap-around is possible within legal parameters.

Decomposition:
- Shared package (receiver_pkg): the state enum adc_state_t and a sample_t typedef (SAMPLE_BITS wide), so the downstream filter uses the same type.
- One natural sub-module: sclk_phase_timer.
  - Counts CLK_DIV clocks and emits a phase_done pulse.
  - Reloads on a start input.
  - The FSM, shift register and output registers stay in adc_spi_sampler.

Test Plan:
- Reset then idle, rst=0 for 3 cycles: cs_n_o=1, sclk_o=1, sample_o=0, valid_o=0, busy_o=0, overrun_o=0 throughout.
- Single conversion, CLK_DIV=2:
  - ADC model drives frame 0x0ABC on falling edges; en_i pulse at t0.
  - cs_n_o falls at t0+1; exactly 16 sclk rising edges occur.
  - valid_o high only at t0+67, with sample_o=0xABC.
- Back-to-back at the limit:
  - Frames 0x0FFF then 0x0001; second en_i in the first IDLE cycle after busy_o falls.
  - Two valid strobes; sample_o=0xFFF then 0x001; overrun_o never asserts.
- Overrun: second en_i at t0+20 during SHIFT -> overrun_o pulse at t0+21; first sample still correct; no second frame starts.
- Reset mid-frame: rst=0 at t0+30 -> cs_n_o=1 and sclk_o=1 at t0+31; no valid_o; the next en_i yields a correct sample.
- Parameter sweep:
  - CLK_DIV=1: valid_o at t0+34.
  - CLK_DIV=5: valid_o at t0+166.
  - Sample values 0x000, 0x800 and 0xFFF are captured bit-exact.
